ltc2344_sample_sequencer: RTL
=============================

# ltc2344_sample_sequencer

Periodic sampling scheduler in front of the LTC2344 CMOS-interface ADC controller.
- Generates timed `extTrig` pulses and owns the SoftSpan word fed to the controller, so range changes only land between conversions.
- Captures the four 16-bit channel results on `dataRdy` and streams them as four beats over a valid/ready interface.
- Flags overruns and lost conversions.

## Interface
Parameters:
- PERIOD_W, 16, width of the trigger-period register
- DEFAULT_SS, 12'hFFF, SoftSpan word after reset (SS7 on all four channels)
- TIMEOUT, 64, cycles to wait for `dataRdy` after a trigger before giving up

Ports:
- serialClock  in  1  sole clock; same clock as the ADC controller
- resetN  in  1  reset, synchronous, active-low
- enable  in  1  run periodic sampling
- period  in  PERIOD_W  trigger interval in cycles; values <8 are treated as 8
- ssReq  in  1  request to load a new SoftSpan word
- ssWord  in  12  requested SoftSpan word
- ssAck  out  1  one-cycle pulse when `ssWord` has been loaded
- softspan  out  12  SoftSpan word to the ADC controller
- extTrig  out  1  conversion trigger to the ADC controller
- dataRdy  in  1  result-ready strobe from the ADC controller
- outData0..outData3  in  16 each  channel results from the ADC controller
- mValid  out  1  stream beat valid
- mReady  in  1  stream beat accepted
- mData  out  16  beat payload
- mChan  out  2  channel index of the current beat
- mLast  out  1  high on the channel-3 beat
- overrun  out  1  sticky; a period tick arrived while a sample was still in flight
- timeout  out  1  sticky; no `dataRdy` within TIMEOUT cycles
- clrStatus  in  1  clears `overrun` and `timeout`
- sampleCount  out  16  number of completed samples; wraps from 0xFFFF to 0

## Operation
- **States:** IDLE, WAIT_TICK, TRIG, WAIT_RDY, DRAIN.
- **Period counter:**
  - Loads max(period,8)−1 whenever `enable` is low, and on the cycle `enable` rises.
  - While `enable` is high it decrements; at 0 it raises `tick` for one cycle and reloads.
- **IDLE:** if `enable` is high, go to WAIT_TICK.
- **WAIT_TICK:**
  - On `tick`, go to TRIG.
  - If `enable` is low, go to IDLE.
- **TRIG:** `extTrig` is high for exactly 4 cycles, then the block enters WAIT_RDY and clears the timeout counter.
- **WAIT_RDY:**
  - A rising edge of `dataRdy` (registered edge detect) latches `outData0..3` into a 4×16 buffer, increments `sampleCount`, and moves to DRAIN.
  - The `dataRdy` level alone is ignored; the controller holds it high for 2 cycles.
  - After TIMEOUT cycles with no edge: set `timeout`, go to WAIT_TICK; no beats are emitted.
- **DRAIN:**
  - Emits beats for channels 0,1,2,3 in order; `mData` is taken from buffer[mChan]; `mLast` is high with mChan=3.
  - After the last beat is accepted: go to WAIT_TICK if `enable` is high, otherwise IDLE.
- **Overrun:** a `tick` in TRIG, WAIT_RDY or DRAIN sets `overrun` and that tick is dropped; there is no queued trigger.
- **SoftSpan update:**
  - `ssReq` is honoured only in IDLE or WAIT_TICK, and not on a cycle where `tick` is high.
  - When honoured: `softspan`←`ssWord` and `ssAck` pulses on the next cycle.
  - Otherwise `ssReq` stays pending; the requester holds `ssReq` and `ssWord` until it sees `ssAck`.
  - `softspan` is constant from TRIG entry through the end of WAIT_RDY.
- **Ignored `dataRdy`:** a `dataRdy` edge outside WAIT_RDY is ignored and does not change `sampleCount`.
- **Status clear:** `clrStatus` clears both sticky flags. If it coincides with a new set event, the set wins.
- **Disabling mid-sample:** dropping `enable` mid-sample does not abort; the current sample completes and drains.

## Timing
- **Reset values:**
  - State IDLE.
  - `extTrig`, `ssAck`, `mValid`, `mLast`, `overrun`, `timeout` all 0.
  - `mData`=0, `mChan`=0, `sampleCount`=0.
  - `softspan`=DEFAULT_SS.
- **Reset mid-operation:** reset returns to all of the above on the next edge; buffered beats are discarded.
- **Trigger timing:** `tick` in cycle N gives `extTrig` high in cycles N+1..N+4.
- **Capture latency:** `dataRdy` rising at edge E gives the buffer captured at E+1 and `mValid` high at E+2 with mChan=0.
- **Stream handshake:**
  - A beat transfers on the edge where `mValid` and `mReady` are both high.
  - While `mValid` is high and `mReady` is low, `mData`, `mChan` and `mLast` are held stable.
  - With `mReady` held high, the four beats take 4 consecutive cycles; `mValid` falls the cycle after the mChan=3 transfer.
- **Minimum period:** period=8 is legal, but with a real ADC it produces `overrun` on every other tick.

## Test plan
- **Periodic sampling:** reset, period=200, enable=1, ADC model returns 16'h1111·(ch+1) → `extTrig` high 4 cycles every 200 cycles; beats 0x1111, 0x2222, 0x3333, 0x4444 with mChan 0..3; `mLast` on beat 3; `sampleCount` increments by 1 per sample.
- **Backpressure:** hold `mReady` low for 10 cycles after `mValid` → `mData`=0x1111 and mChan=0 held unchanged; the remaining beats follow in order once `mReady` is high.
- **SoftSpan update:**
  - Raise `ssReq` with `ssWord`=12'h5A5 during WAIT_RDY → no `ssAck` until WAIT_TICK; `softspan` unchanged during the conversion.
  - After `ssAck`, the next conversion sees `softspan`=12'h5A5.
- **Overrun:** period=8 with the ADC model taking 40 cycles → `overrun`=1.
  - Pulse `clrStatus` in the same cycle as the next dropped tick → `overrun` stays 1.
  - Pulse `clrStatus` alone → `overrun` clears.
- **Timeout:** ADC model never asserts `dataRdy` → `timeout`=1 exactly TIMEOUT cycles after `extTrig` falls; no beats emitted; triggering resumes on the next tick.
- **Reset and wrap:**
  - Assert `resetN`=0 during DRAIN beat 2 → all outputs return to their reset values next cycle; `softspan`=12'hFFF.
  - Preload `sampleCount` to 0xFFFF via a forced run → it wraps to 0.

Source files
------------

// File: rtl/ltc2344_sample_sequencer.sv
// Periodic trigger scheduler for the LTC2344 ADC controller: owns the SoftSpan word,
// captures the four channel results and streams them as four valid/ready beats.
module ltc2344_sample_sequencer #(
    parameter int          PERIOD_W   = 16,
    parameter logic [11:0] DEFAULT_SS = 12'hFFF,
    parameter int          TIMEOUT    = 64
) (
    input  logic                serialClock,
    input  logic                resetN,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                ssReq,
    input  logic [11:0]         ssWord,
    output logic                ssAck,
    output logic [11:0]         softspan,
    output logic                extTrig,
    input  logic                dataRdy,
    input  logic [15:0]         outData0,
    input  logic [15:0]         outData1,
    input  logic [15:0]         outData2,
    input  logic [15:0]         outData3,
    output logic                mValid,
    input  logic                mReady,
    output logic [15:0]         mData,
    output logic [1:0]          mChan,
    output logic                mLast,
    output logic                overrun,
    output logic                timeout,
    input  logic                clrStatus,
    output logic [15:0]         sampleCount,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_TRIG      = 3'd2,
        S_WAIT_RDY  = 3'd3,
        S_DRAIN     = 3'd4
    } state_t;

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_enable_d;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic [1:0]          r_trig_cnt;
    logic [TO_W-1:0]     r_to_cnt;
    logic                r_rdy_d;
    logic                r_rdy_rise;
    logic [15:0]         r_buf [4];
    logic [1:0]          r_beat;
    logic [15:0]         r_sample_cnt;
    logic [11:0]         r_softspan;
    logic                r_ss_ack;
    logic                r_overrun;
    logic                r_timeout;

    logic [PERIOD_W-1:0] w_period_load;
    logic                w_tick;
    logic                w_xfer;
    logic                w_capture;
    logic                w_to_fire;
    logic                w_ss_take;
    logic                w_ovr_set;

    assign w_period_load = (period < PERIOD_W'(8)) ? PERIOD_W'(7) : period - PERIOD_W'(1);
    // The counter reloads while disabled and on the rising cycle, so no tick can fire there.
    assign w_tick    = enable && r_enable_d && (r_period_cnt == '0);
    assign w_capture = (r_state == S_WAIT_RDY) && r_rdy_rise;
    assign w_to_fire = (r_state == S_WAIT_RDY) && !r_rdy_rise && (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_ovr_set = w_tick && ((r_state == S_TRIG) || (r_state == S_WAIT_RDY) || (r_state == S_DRAIN));
    // r_ss_ack blocks a second load while the requester is still holding ssReq.
    assign w_ss_take = ssReq && !r_ss_ack && !w_tick &&
                       ((r_state == S_IDLE) || (r_state == S_WAIT_TICK));

    // Stream: a beat moves on any edge with mValid && mReady; payload changes only after a transfer.
    assign mValid      = (r_state == S_DRAIN);
    assign w_xfer      = mValid && mReady;
    assign mData       = mValid ? r_buf[r_beat] : 16'h0000;
    assign mChan       = r_beat;
    assign mLast       = mValid && (r_beat == 2'd3);
    assign extTrig     = (r_state == S_TRIG);
    assign ssAck       = r_ss_ack;
    assign softspan    = r_softspan;
    assign overrun     = r_overrun;
    assign timeout     = r_timeout;
    assign sampleCount = r_sample_cnt;
    assign o_dbg_state = r_state;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (enable) w_next_state = S_WAIT_TICK;
            S_WAIT_TICK: begin
                if (w_tick)       w_next_state = S_TRIG;
                else if (!enable) w_next_state = S_IDLE;
            end
            S_TRIG:      if (r_trig_cnt == 2'd3) w_next_state = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (w_capture)      w_next_state = S_DRAIN;
                else if (w_to_fire) w_next_state = S_WAIT_TICK;
            end
            S_DRAIN:     if (w_xfer && (r_beat == 2'd3)) w_next_state = enable ? S_WAIT_TICK : S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge serialClock) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_enable_d   <= 1'b0;
            r_period_cnt <= '0;
            r_trig_cnt   <= 2'd0;
            r_to_cnt     <= '0;
            r_rdy_d      <= 1'b0;
            r_rdy_rise   <= 1'b0;
            r_beat       <= 2'd0;
            r_sample_cnt <= 16'h0000;
            r_softspan   <= DEFAULT_SS;
            r_ss_ack     <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
            for (int i = 0; i < 4; i++) r_buf[i] <= 16'h0000;
        end else begin
            r_state    <= w_next_state;
            r_enable_d <= enable;
            r_rdy_d    <= dataRdy;
            r_rdy_rise <= dataRdy && !r_rdy_d;

            if (!enable || !r_enable_d || (r_period_cnt == '0)) r_period_cnt <= w_period_load;
            else                                                 r_period_cnt <= r_period_cnt - PERIOD_W'(1);

            r_trig_cnt <= (r_state == S_TRIG) ? r_trig_cnt + 2'd1 : 2'd0;
            r_to_cnt   <= (r_state == S_WAIT_RDY) ? r_to_cnt + TO_W'(1) : '0;

            if (w_capture) begin
                r_buf[0]     <= outData0;
                r_buf[1]     <= outData1;
                r_buf[2]     <= outData2;
                r_buf[3]     <= outData3;
                r_sample_cnt <= r_sample_cnt + 16'd1;
            end

            if (w_xfer) r_beat <= r_beat + 2'd1;

            r_ss_ack <= w_ss_take;
            if (w_ss_take) r_softspan <= ssWord;

            if (w_ovr_set)      r_overrun <= 1'b1;
            else if (clrStatus) r_overrun <= 1'b0;

            if (w_to_fire)      r_timeout <= 1'b1;
            else if (clrStatus) r_timeout <= 1'b0;
        end
    end

endmodule
